load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-access initiator for the multi-cycle CPU: accepts one load/store request from the datapath, drives the word-addressed, big-endian data memory port (DAddr, DataIn, mRD, mWR, DataOut), and returns the sign/zero-extended load result. Word, halfword and byte operations are supported. Sub-word stores use read-modify-write, because the memory writes whole 32-bit words only. Misaligned and out-of-range accesses are rejected with an error and never reach memory.

## Interface
- MEM_BYTES, 121: byte size of the attached data memory; valid byte addresses are 0..MEM_BYTES-1.
- clk  in  1  clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-low reset.
- req  in  1  request strobe; sampled only in IDLE.
- op  in  3  operation: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
- addr  in  32  byte address.
- wdata  in  32  store data; SH uses [15:0], SB uses [7:0].
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 means the access was rejected.
- rdata  out  32  load result; holds its value until the next completed load.
- DAddr  out  32  word-aligned memory address, {addr[31:2],2'b00}.
- DataIn  out  32  memory write data.
- mRD  out  1  memory read enable.
- mWR  out  1  memory write enable; memory writes on the rising edge while high.
- DataOut  in  32  memory read data; combinational from DAddr/mRD.

## Operation
- States: IDLE, READ, WRITE, DONE.
- In IDLE with req=1, latch op, addr and wdata, then check the request:
  - Misaligned if LW/SW with addr[1:0]≠0, or LH/LHU/SH with addr[0]≠0.
  - Out of range if {addr[31:2],2'b00}+3 > MEM_BYTES-1.
  - A failing request goes to DONE with err=1 and no mRD/mWR pulse.
- Passing requests:
  - Loads and SH/SB go to READ.
  - SW goes to WRITE.
- READ: drive mRD=1 and DAddr. At the end of the cycle, capture DataOut.
  - Loads: extract and extend into rdata, then go to DONE.
  - SH/SB: merge the store data into the captured word, then go to WRITE.
- WRITE: drive mWR=1, DAddr, and DataIn (wdata for SW, merged word for SH/SB). Then go to DONE.
- DONE: done=1, err valid. Always return to IDLE. req is ignored in DONE.
- Byte lanes are big-endian:
  - Byte at addr[1:0]=0 is bits [31:24]; 1→[23:16]; 2→[15:8]; 3→[7:0].
  - Halfword at addr[1]=0 is [31:16]; addr[1]=1 is [15:0].
- Load extension: LB/LH sign-extend; LBU/LHU zero-extend. Non-selected lanes of a merged store keep their read value.
- mRD and mWR are never high in the same cycle. mRD is low in IDLE and DONE, so every read presents a fresh mRD rising edge to the memory.
- DAddr, DataIn and the latched fields stay stable for the whole request. In IDLE, DAddr=0 and DataIn=0.

## Timing
- Reset (Reset=0 at an edge): state IDLE; busy=0, done=0, err=0, rdata=0, mRD=0, mWR=0, DAddr=0, DataIn=0.
- Reset mid-operation aborts the request with no done pulse. If mWR was high at that same edge, the memory still performs that write; this is accepted behaviour.
- Request accepted at edge E0. Cycles after E0 to the done cycle:
  - Loads: READ in cycle 1, done in cycle 2.
  - SW: WRITE in cycle 1, done in cycle 2.
  - SH/SB: READ in cycle 1, WRITE in cycle 2, done in cycle 3.
  - Error: done in cycle 1.
- rdata updates at the end of READ and is valid when done is high.
- req held high continuously: a new request is accepted in the first IDLE cycle after DONE. Minimum request spacing is therefore 3 cycles (loads, SW) or 4 cycles (SH/SB).
- done stays high for exactly one cycle.

## Test plan
- SW: addr=8, wdata=0x11223344 → mWR one cycle with DAddr=8, DataIn=0x11223344; done 2 cycles after acceptance, err=0. Then LW addr=8 → rdata=0x11223344.
- Memory word 0x80F0_7F01 at byte address 8:
  - LB addr=9 → 0xFFFFFFF0.
  - LBU addr=9 → 0x000000F0.
  - LH addr=10 → 0x00007F01.
  - LH addr=8 → 0xFFFF80F0.
- SB addr=11, wdata=0xAB over word 0x11223344 → READ then WRITE with DataIn=0x112233AB; done in cycle 3.
- SH addr=10, wdata=0xBEEF over the same word → DataIn=0x1122BEEF.
- Errors, each giving done with err=1, no mRD/mWR, and rdata unchanged:
  - LW addr=6.
  - SH addr=3.
  - LW addr=120 (MEM_BYTES=121).
- Reset driven low during the WRITE cycle of an SB → next cycle IDLE, all outputs at reset values, no done. A following LW completes normally.
- req held high with two queued LWs to addresses 0 and 4 → mRD has a rising edge for each read, done pulses 3 cycles apart, and each rdata is correct.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
// Memory-access initiator for the multi-cycle CPU. Takes one load/store
// request at a time, drives a word-addressed big-endian data memory and
// returns the sign/zero-extended load result. Sub-word stores are done as a
// read-modify-write because the memory only writes whole words. Misaligned
// or out-of-range requests are rejected without touching memory.
//
// Ports:
//   clk      clock, rising edge
//   Reset    synchronous active-low reset
//   req      request strobe, sampled in IDLE only
//   op       000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB
//   addr     byte address
//   wdata    store data (SH uses [15:0], SB uses [7:0])
//   busy     high whenever not IDLE
//   done     one-cycle completion pulse
//   err      valid with done; 1 = request rejected
//   rdata    last completed load result
//   DAddr    word-aligned memory address (0 in IDLE)
//   DataIn   memory write data (0 in IDLE)
//   mRD      memory read enable
//   mWR      memory write enable
//   DataOut  memory read data (combinational from DAddr/mRD)
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 32'd121
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] DAddr,
    output logic [31:0] DataIn,
    output logic        mRD,
    output logic        mWR,
    input  logic [31:0] DataOut
);

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    // One bit wider than the address so a word near 2^32 cannot wrap into range.
    localparam logic [32:0] LAST_BYTE = 33'(MEM_BYTES) - 33'd1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic is_store(input logic [2:0] f_op);
        is_store = (f_op == OP_SW) || (f_op == OP_SH) || (f_op == OP_SB);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f_op, input logic [1:0] f_lo);
        case (f_op)
            OP_LW, OP_SW:         is_misaligned = (f_lo != 2'b00);
            OP_LH, OP_LHU, OP_SH: is_misaligned = f_lo[0];
            default:              is_misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic is_out_of_range(input logic [31:0] f_addr);
        logic [32:0] last_s;
        last_s = {1'b0, f_addr[31:2], 2'b00} + 33'd3;
        is_out_of_range = (last_s > LAST_BYTE);
    endfunction

    // Big-endian lane select followed by sign or zero extension.
    function automatic logic [31:0] load_extract(input logic [2:0] f_op, input logic [1:0] f_lo,
                                                 input logic [31:0] f_word);
        logic [7:0]  b_s;
        logic [15:0] h_s;
        case (f_lo)
            2'd0:    b_s = f_word[31:24];
            2'd1:    b_s = f_word[23:16];
            2'd2:    b_s = f_word[15:8];
            default: b_s = f_word[7:0];
        endcase
        h_s = f_lo[1] ? f_word[15:0] : f_word[31:16];
        case (f_op)
            OP_LH:   load_extract = {{16{h_s[15]}}, h_s};
            OP_LHU:  load_extract = {16'h0000, h_s};
            OP_LB:   load_extract = {{24{b_s[7]}}, b_s};
            OP_LBU:  load_extract = {24'h000000, b_s};
            default: load_extract = f_word;
        endcase
    endfunction

    // Replace the addressed big-endian lane(s); other lanes keep the read value.
    function automatic logic [31:0] store_merge(input logic [2:0] f_op, input logic [1:0] f_lo,
                                                input logic [31:0] f_word, input logic [15:0] f_wd);
        logic [31:0] m_s;
        m_s = f_word;
        case (f_op)
            OP_SH: begin
                if (f_lo[1]) m_s[15:0]  = f_wd;
                else         m_s[31:16] = f_wd;
            end
            OP_SB: begin
                case (f_lo)
                    2'd0:    m_s[31:24] = f_wd[7:0];
                    2'd1:    m_s[23:16] = f_wd[7:0];
                    2'd2:    m_s[15:8]  = f_wd[7:0];
                    default: m_s[7:0]   = f_wd[7:0];
                endcase
            end
            default: m_s = f_word;
        endcase
        store_merge = m_s;
    endfunction

    state_t      state_r;
    state_t      next_state_s;
    logic        reject_s;
    logic [2:0]  op_r;
    logic [1:0]  addr_lo_r;
    logic [15:0] wdata_lo_r;
    logic        busy_r, done_r, err_r, mrd_r, mwr_r;
    logic [31:0] rdata_r, daddr_r, data_in_r;

    assign reject_s = is_misaligned(op, addr[1:0]) | is_out_of_range(addr);

    // State register.
    always_ff @(posedge clk) begin
        if (!Reset) state_r <= ST_IDLE;
        else        state_r <= next_state_s;
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!req)                next_state_s = ST_IDLE;
                else if (reject_s)       next_state_s = ST_DONE;
                else if (op == OP_SW)    next_state_s = ST_WRITE;
                else                     next_state_s = ST_READ;
            end
            ST_READ: begin
                if (is_store(op_r))      next_state_s = ST_WRITE;
                else                     next_state_s = ST_DONE;
            end
            ST_WRITE: next_state_s = ST_DONE;
            ST_DONE:  next_state_s = ST_IDLE;
            default:  next_state_s = ST_IDLE;
        endcase
    end

    // Control outputs registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
            mrd_r  <= 1'b0;
            mwr_r  <= 1'b0;
        end else begin
            busy_r <= (next_state_s != ST_IDLE);
            done_r <= (next_state_s == ST_DONE);
            // A rejected request is the only path from IDLE straight to DONE.
            err_r  <= (state_r == ST_IDLE) && req && reject_s;
            mrd_r  <= (next_state_s == ST_READ);
            mwr_r  <= (next_state_s == ST_WRITE);
        end
    end

    // Request latch, memory address/data and load result.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            op_r       <= 3'd0;
            addr_lo_r  <= 2'd0;
            wdata_lo_r <= 16'h0000;
            daddr_r    <= 32'h0000_0000;
            data_in_r  <= 32'h0000_0000;
            rdata_r    <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req) begin
                        op_r       <= op;
                        addr_lo_r  <= addr[1:0];
                        wdata_lo_r <= wdata[15:0];
                        // Rejected requests leave the memory port at zero.
                        if (!reject_s) daddr_r <= {addr[31:2], 2'b00};
                        if (!reject_s && (op == OP_SW)) data_in_r <= wdata;
                    end
                end
                ST_READ: begin
                    if (is_store(op_r)) data_in_r <= store_merge(op_r, addr_lo_r, DataOut, wdata_lo_r);
                    else                rdata_r   <= load_extract(op_r, addr_lo_r, DataOut);
                end
                ST_WRITE: begin
                    data_in_r <= data_in_r;
                end
                ST_DONE: begin
                    daddr_r   <= 32'h0000_0000;
                    data_in_r <= 32'h0000_0000;
                end
                default: begin
                    daddr_r   <= 32'h0000_0000;
                    data_in_r <= 32'h0000_0000;
                end
            endcase
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign err    = err_r;
    assign mRD    = mrd_r;
    assign mWR    = mwr_r;
    assign rdata  = rdata_r;
    assign DAddr  = daddr_r;
    assign DataIn = data_in_r;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int unsigned MEM_BYTES = 121;
    localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3,
                           LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

    logic        clk = 1'b0;
    logic        Reset = 1'b0;
    logic        req = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic        busy, done, err, mRD, mWR;
    logic [31:0] rdata, DAddr, DataIn, DataOut;

    load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk(clk), .Reset(Reset), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .err(err), .rdata(rdata),
        .DAddr(DAddr), .DataIn(DataIn), .mRD(mRD), .mWR(mWR), .DataOut(DataOut)
    );

    always #5 clk = ~clk;

    // Physical data memory seen by the DUT: 31 words, write on rising edge.
    logic [31:0] mem_w [0:30];
    always @(posedge clk) begin
        if (mWR && (DAddr[31:2] < 30'd31)) mem_w[DAddr[6:2]] <= DataIn;
    end
    assign DataOut = (mRD && (DAddr[31:2] < 30'd31)) ? mem_w[DAddr[6:2]] : 32'h0;

    int unsigned cyc = 0;
    logic        rst_q = 1'b0;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= Reset;
    end

    typedef struct {
        int unsigned k;
        int          lat;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] waddr;
        logic [31:0] wword;
        int          n_rd;
        int          n_wr;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  ref_mem [0:MEM_BYTES-1];
    logic [31:0] ref_rdata = 32'h0;
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Byte-array reference: memory as bytes, accesses as byte sequences.
    function automatic exp_t predict(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w);
        exp_t e;
        int sz;
        longint unsigned b, base;
        logic [31:0] v;
        sz = (o == LW || o == SW) ? 4 : ((o == LH || o == LHU || o == SH) ? 2 : 1);
        b = longint'(a);
        base = b - (b % 4);
        e.err = ((b % sz) != 0) || (base + 3 > MEM_BYTES - 1);
        e.waddr = 32'(base);
        e.wword = 32'h0;
        e.n_rd = 0; e.n_wr = 0; e.lat = 1; e.k = 0;
        if (!e.err) begin
            if (o < SW) begin
                v = 32'h0;
                for (int i = 0; i < sz; i++) v = (v << 8) | {24'h0, ref_mem[int'(b) + i]};
                if ((o == LB || o == LH) && v[sz*8-1]) v = v | (32'hFFFF_FFFF << (sz*8));
                ref_rdata = v;
                e.n_rd = 1; e.lat = 2;
            end else begin
                for (int i = 0; i < sz; i++) ref_mem[int'(b) + i] = 8'(w >> (8*(sz-1-i)));
                e.wword = {ref_mem[int'(base)], ref_mem[int'(base)+1], ref_mem[int'(base)+2], ref_mem[int'(base)+3]};
                e.n_wr = 1;
                e.n_rd = (o == SW) ? 0 : 1;
                e.lat  = (o == SW) ? 2 : 3;
            end
        end
        e.rdata = ref_rdata;
        return e;
    endfunction

    // Scoreboard monitor: samples on the falling edge.
    task automatic monitor();
        exp_t e;
        logic prev_rd = 1'b0;
        int rd_cnt = 0, wr_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_q) begin
                chk("rst_busy", {31'h0, busy}, 32'h0);
                chk("rst_done", {31'h0, done}, 32'h0);
                chk("rst_err", {31'h0, err}, 32'h0);
                chk("rst_mRD", {31'h0, mRD}, 32'h0);
                chk("rst_mWR", {31'h0, mWR}, 32'h0);
                chk("rst_rdata", rdata, 32'h0);
                chk("rst_DAddr", DAddr, 32'h0);
                chk("rst_DataIn", DataIn, 32'h0);
                prev_rd = 1'b0; rd_cnt = 0; wr_cnt = 0;
            end else begin
                if (mRD || mWR) begin
                    chk("rd_wr_exclusive", {31'h0, mRD & mWR}, 32'h0);
                    if (sb.size() == 0) chk("unexpected_access", 32'h1, 32'h0);
                    else begin
                        chk("DAddr", DAddr, sb[0].waddr);
                        if (mWR) chk("DataIn", DataIn, sb[0].wword);
                    end
                end
                if (!busy) begin
                    chk("idle_DAddr", DAddr, 32'h0);
                    chk("idle_DataIn", DataIn, 32'h0);
                end
                if (err) chk("err_with_done", {31'h0, done}, 32'h1);
                if (mRD && !prev_rd) rd_cnt++;
                if (mWR) wr_cnt++;
                if (done) begin
                    if (sb.size() == 0) chk("spurious_done", 32'h1, 32'h0);
                    else begin
                        e = sb.pop_front();
                        chk("latency", cyc - e.k, 32'(e.lat));
                        chk("err", {31'h0, err}, {31'h0, e.err});
                        chk("rdata", rdata, e.rdata);
                        chk("mRD_edges", 32'(rd_cnt), 32'(e.n_rd));
                        chk("mWR_cycles", 32'(wr_cnt), 32'(e.n_wr));
                    end
                    rd_cnt = 0; wr_cnt = 0;
                end else if (!busy) begin
                    rd_cnt = 0; wr_cnt = 0;
                end
                prev_rd = mRD;
            end
        end
    endtask

    // Driver works at posedge+1; returns one step after the accepting edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w, input bit hold);
        exp_t e;
        for (int i = 0; i < 20 && busy; i++) begin @(posedge clk); #1; end
        chk("idle_before_issue", {31'h0, busy}, 32'h0);
        e = predict(o, a, w);
        e.k = cyc;
        sb.push_back(e);
        req = 1'b1; op = o; addr = a; wdata = w;
        @(posedge clk); #1;
        if (!hold) req = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin @(posedge clk); #1; end
        chk("drain_timeout", 32'(sb.size()), 32'h0);
        sb.delete();
    endtask

    initial begin
        exp_t e;
        logic [31:0] word;
        fork
            monitor();
        join_none
        repeat (2) @(posedge clk);
        #1 Reset = 1'b1;

        // Fill memory through the DUT with random words.
        for (int i = 0; i < 30; i++) issue(SW, 32'(i*4), $urandom, 1'b0);
        drain();

        // Directed cases.
        issue(SW, 32'd8, 32'h1122_3344, 1'b0);
        issue(LW, 32'd8, 32'h0, 1'b0);
        issue(SW, 32'd8, 32'h80F0_7F01, 1'b0);
        issue(LB, 32'd9, 32'h0, 1'b0);
        issue(LBU, 32'd9, 32'h0, 1'b0);
        issue(LH, 32'd10, 32'h0, 1'b0);
        issue(LH, 32'd8, 32'h0, 1'b0);
        issue(SW, 32'd8, 32'h1122_3344, 1'b0);
        issue(SB, 32'd11, 32'h0000_00AB, 1'b0);
        issue(SW, 32'd8, 32'h1122_3344, 1'b0);
        issue(SH, 32'd10, 32'h0000_BEEF, 1'b0);
        issue(LW, 32'd6, 32'h0, 1'b0);
        issue(SH, 32'd3, 32'h0, 1'b0);
        issue(LW, 32'd120, 32'h0, 1'b0);
        issue(LW, 32'd116, 32'h0, 1'b0);
        issue(LW, 32'hFFFF_FFFC, 32'h0, 1'b0);
        drain();

        // Reset during the WRITE cycle of an SB; the memory still writes.
        issue(SB, 32'd21, 32'h0000_005A, 1'b0);
        for (int i = 0; i < 10 && !mWR; i++) begin @(posedge clk); #1; end
        chk("sb_reached_write", {31'h0, mWR}, 32'h1);
        Reset = 1'b0;
        @(posedge clk); #1;
        Reset = 1'b1;
        void'(sb.pop_back());
        ref_rdata = 32'h0;
        issue(LW, 32'd20, 32'h0, 1'b0);
        drain();

        // req held high across two LWs.
        issue(LW, 32'd0, 32'h0, 1'b1);
        addr = 32'd4;
        e = predict(LW, 32'd4, 32'h0);
        e.k = cyc + 2;
        sb.push_back(e);
        repeat (3) begin @(posedge clk); #1; end
        req = 1'b0;
        drain();

        // Randomized traffic.
        for (int n = 0; n < 200; n++) begin
            logic [2:0]  ro;
            logic [31:0] ra;
            ro = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 127));
            issue(ro, ra, $urandom, 1'b0);
        end
        drain();

        // Final memory image against the byte reference.
        for (int i = 0; i < 30; i++) begin
            word = {ref_mem[i*4], ref_mem[i*4+1], ref_mem[i*4+2], ref_mem[i*4+3]};
            chk("mem_image", mem_w[i], word);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
